// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared segment constants and hex font for the seven-segment scan driver
package seven_seg_pkg;

  localparam int SEG_N = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // gfedcba, bit SEG_A is segment a
  localparam logic [SEG_N-1:0] FONT [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [SEG_N-1:0] hex2seg(input logic [3:0] nib);
    return FONT[nib];
  endfunction

endpackage

// File: rtl/seven_seg_font.sv
// rtl/seven_seg_font.sv - combinational hex nibble to gfedcba segment pattern
module seven_seg_font
  import seven_seg_pkg::*;
(
  input  logic [3:0]       i_nib,
  output logic [SEG_N-1:0] o_seg
);

  assign o_seg = hex2seg(i_nib);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - multiplexed N-digit seven-segment driver with double buffer, blanking and PWM
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_W          = 16,
  parameter int BRIGHT_W       = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    lzb_i,
  input  logic [DIV_W-1:0]        div_i,
  input  logic [BRIGHT_W-1:0]     bright_i,
  output logic [SEG_N-1:0]        seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic                    frame_o
);

  localparam int   IDX_W   = $clog2(NUM_DIGITS);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  logic [DIV_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [BRIGHT_W-1:0]     r_pwm;
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_flag;
  logic                    r_en_d;

  logic [SEG_N-1:0]        r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_frame;

  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_rise;
  logic                    w_promote;
  logic [4*NUM_DIGITS-1:0] w_new_data;
  logic [NUM_DIGITS-1:0]   w_new_dp;
  logic [4*NUM_DIGITS-1:0] w_disp_data;
  logic [NUM_DIGITS-1:0]   w_disp_dp;
  logic [3:0]              w_nib;
  logic [SEG_N-1:0]        w_font_seg;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic                    w_zero_above;
  logic                    w_cur_blank;
  logic                    w_lit;
  logic                    w_guard;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [SEG_N-1:0]        w_seg_n;
  logic                    w_dp_n;
  logic [NUM_DIGITS-1:0]   w_dig_n;

  assign w_tick    = en_i && (r_cnt >= div_i);
  assign w_wrap    = w_tick && (r_idx == IDX_W'(NUM_DIGITS-1));
  assign w_rise    = en_i && !r_en_d;
  assign w_promote = (w_wrap || w_rise) && (load_i || r_pend_flag);

  assign w_new_data = load_i ? data_i : r_pend_data;
  assign w_new_dp   = load_i ? dp_i   : r_pend_dp;

  // The first slot after enable already shows the data being promoted that cycle
  assign w_disp_data = (w_rise && w_promote) ? w_new_data : r_act_data;
  assign w_disp_dp   = (w_rise && w_promote) ? w_new_dp   : r_act_dp;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pwm       <= '0;
      r_act_data  <= '0;
      r_pend_data <= '0;
      r_act_dp    <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
      r_en_d      <= 1'b0;
    end else begin
      r_en_d <= en_i;
      if (en_i) begin
        r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
        if (w_tick) r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
        if (w_wrap) r_pwm <= r_pwm + BRIGHT_W'(1);
      end else begin
        r_cnt <= '0;
        r_idx <= '0;
      end
      if (w_promote) begin
        r_act_data  <= w_new_data;
        r_act_dp    <= w_new_dp;
        r_pend_flag <= 1'b0;
      end else if (load_i) begin
        r_pend_data <= data_i;
        r_pend_dp   <= dp_i;
        r_pend_flag <= 1'b1;
      end
    end
  end

  assign w_nib = w_disp_data[{r_idx, 2'b00} +: 4];

  seven_seg_font u_font (
    .i_nib (w_nib),
    .o_seg (w_font_seg)
  );

  // Walk from the most significant digit down, tracking "everything above is zero"
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero_above = w_zero_above && (w_disp_data[4*k +: 4] == 4'd0);
      w_blank[k]   = lzb_i && w_zero_above && !w_disp_dp[k];
    end
  end

  assign w_cur_blank = w_blank[r_idx];
  assign w_lit       = (&bright_i) || (r_pwm < bright_i);
  assign w_guard     = (div_i != '0) && (r_cnt == '0);
  assign w_onehot    = NUM_DIGITS'(1) << r_idx;

  assign w_seg_n = (en_i && !w_cur_blank) ? w_font_seg : '0;
  assign w_dp_n  = en_i && !w_cur_blank && w_disp_dp[r_idx];
  assign w_dig_n = (en_i && w_lit && !w_guard) ? w_onehot : '0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_seg   <= {SEG_N{SEG_INV}};
      r_dp    <= SEG_INV;
      r_dig   <= {NUM_DIGITS{DIG_INV}};
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_seg_n ^ {SEG_N{SEG_INV}};
      r_dp    <= w_dp_n ^ SEG_INV;
      r_dig   <= w_dig_n ^ {NUM_DIGITS{DIG_INV}};
      r_frame <= w_wrap;
    end
  end

  assign seg_o   = r_seg;
  assign dp_o    = r_dp;
  assign dig_o   = r_dig;
  assign frame_o = r_frame;

endmodule
